// File: rtl/pipe_run_ctrl.sv
// Run/step/debug sequencer for the 5-stage pipeline: drives pipeline enable, fetch hold and pipeline
// reset, lends the data memory port to the host, and answers one response per accepted host command.
module pipe_run_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned RST_CYCLES   = 3,
    parameter int unsigned DM_LATENCY   = 1,
    parameter int unsigned AW           = 12
) (
    input  logic          clk,
    input  logic          inicio,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    input  logic          halt_wb,
    output logic          pipe_en,
    output logic          fetch_hold,
    output logic          pipe_rst,
    output logic          dm_sel,
    output logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_rdata,
    output logic [31:0]   cycle_cnt,
    output logic [2:0]    state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RUN    = 3'd1;
    localparam logic [2:0] STEP   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;
    localparam logic [2:0] MEMRD  = 3'd5;
    localparam logic [2:0] RESP   = 3'd6;
    localparam logic [2:0] RST    = 3'd7;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_STEP    = 3'd2;
    localparam logic [2:0] OP_STOP    = 3'd3;
    localparam logic [2:0] OP_RDMEM   = 3'd4;
    localparam logic [2:0] OP_RSTPIPE = 3'd5;
    localparam logic [2:0] OP_RDCNT   = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    localparam int unsigned   CW         = 8;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] MEM_WAIT   = CW'(DM_LATENCY);

    logic [2:0]    stateNext;
    logic [2:0]    retState;
    logic [2:0]    retNext;
    logic [CW-1:0] phaseCnt;
    logic [CW-1:0] phaseNext;
    logic          accept;
    logic          rspSet;
    logic [31:0]   rspDataNext;
    logic          rspErrNext;
    logic          rspValidNext;
    logic          dmLoad;

    assign accept       = cmd_valid && cmd_ready;
    assign rspValidNext = rspSet || (rsp_valid && !rsp_ready);

    always_comb begin
        stateNext   = state;
        retNext     = retState;
        phaseNext   = phaseCnt;
        rspSet      = 1'b0;
        rspDataNext = '0;
        rspErrNext  = 1'b0;
        dmLoad      = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (accept) begin
                    retNext = state;
                    case (cmd_op)
                        OP_RUN: begin
                            stateNext = RUN;
                            rspSet    = 1'b1;
                        end
                        OP_STEP: stateNext = STEP;
                        OP_RDMEM: begin
                            stateNext = MEMRD;
                            phaseNext = '0;
                            dmLoad    = 1'b1;
                        end
                        OP_RSTPIPE: begin
                            stateNext = RST;
                            phaseNext = RST_LOAD;
                        end
                        OP_RDCNT: begin
                            stateNext   = RESP;
                            rspSet      = 1'b1;
                            rspDataNext = cycle_cnt;
                        end
                        default: begin
                            stateNext  = RESP;
                            rspSet     = 1'b1;
                            rspErrNext = (cmd_op == OP_RSVD);
                        end
                    endcase
                end
            end
            RUN: begin
                // Responses issued while running go to the side register; the FSM keeps running.
                if (accept) begin
                    rspSet = 1'b1;
                    case (cmd_op)
                        OP_RDCNT: rspDataNext = cycle_cnt;
                        OP_STOP: begin
                            stateNext = DRAIN;
                            phaseNext = DRAIN_LOAD;
                        end
                        OP_NOP:  rspErrNext = 1'b0;
                        default: rspErrNext = 1'b1;
                    endcase
                end
                if (halt_wb) begin
                    stateNext = HALTED;
                end
            end
            STEP: begin
                stateNext = RESP;
                rspSet    = 1'b1;
                retNext   = halt_wb ? HALTED : retState;
            end
            DRAIN: begin
                if (halt_wb || (phaseCnt == '0)) begin
                    stateNext = HALTED;
                end else begin
                    phaseNext = phaseCnt - 1'b1;
                end
            end
            MEMRD: begin
                if (phaseCnt == MEM_WAIT) begin
                    stateNext   = RESP;
                    rspSet      = 1'b1;
                    rspDataNext = dm_rdata;
                end else begin
                    phaseNext = phaseCnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    stateNext = retState;
                end
            end
            RST: begin
                if (phaseCnt == '0) begin
                    stateNext = RESP;
                    retNext   = IDLE;
                    rspSet    = 1'b1;
                end else begin
                    phaseNext = phaseCnt - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Every output is registered from the next-state decode, so it lines up with the state it describes.
    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) begin
            state      <= IDLE;
            retState   <= IDLE;
            phaseCnt   <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            pipe_en    <= 1'b0;
            fetch_hold <= 1'b0;
            pipe_rst   <= 1'b1;
            dm_sel     <= 1'b0;
            dm_addr    <= '0;
            cycle_cnt  <= '0;
        end else begin
            state      <= stateNext;
            retState   <= retNext;
            phaseCnt   <= phaseNext;
            cmd_ready  <= ((stateNext == IDLE) || (stateNext == HALTED) || (stateNext == RUN))
                          && !rspValidNext;
            rsp_valid  <= rspValidNext;
            if (rspSet) begin
                rsp_data <= rspDataNext;
                rsp_err  <= rspErrNext;
            end
            pipe_en    <= (stateNext == RUN) || (stateNext == STEP) || (stateNext == DRAIN);
            fetch_hold <= (stateNext == DRAIN);
            pipe_rst   <= (stateNext == RST);
            dm_sel     <= (stateNext == MEMRD);
            if (dmLoad) begin
                dm_addr <= cmd_addr;
            end
            if (stateNext == RST) begin
                cycle_cnt <= '0;
            end else if (pipe_en && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: directed scenarios then randomized command sequences,
// checked against a transaction-level model of the active-cycle count and the controller mode.
`timescale 1ns/1ps
module tb_pipe_run_ctrl;

    localparam int unsigned DRAIN = 4;
    localparam int unsigned RSTC  = 3;
    localparam int unsigned LAT   = 1;
    localparam int unsigned AW    = 12;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2, S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4, S_MEMRD = 3'd5, S_RESP = 3'd6, S_RST = 3'd7;
    localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_STEP = 3'd2, OP_STOP = 3'd3;
    localparam logic [2:0] OP_RDMEM = 3'd4, OP_RSTPIPE = 3'd5, OP_RDCNT = 3'd6, OP_RSVD = 3'd7;

    logic          clk = 1'b0;
    logic          inicio = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          halt_wb = 1'b0;
    logic          pipe_en;
    logic          fetch_hold;
    logic          pipe_rst;
    logic          dm_sel;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_rdata;
    logic [31:0]   cycle_cnt;
    logic [2:0]    state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mCnt = '0;
    logic [2:0]  mMode = S_IDLE;

    always #5 clk = ~clk;

    pipe_run_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .RST_CYCLES  (RSTC),
        .DM_LATENCY  (LAT),
        .AW          (AW)
    ) dut (
        .clk       (clk),
        .inicio    (inicio),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .halt_wb   (halt_wb),
        .pipe_en   (pipe_en),
        .fetch_hold(fetch_hold),
        .pipe_rst  (pipe_rst),
        .dm_sel    (dm_sel),
        .dm_addr   (dm_addr),
        .dm_rdata  (dm_rdata),
        .cycle_cnt (cycle_cnt),
        .state     (state)
    );

    function automatic logic [31:0] memWord(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {a, 8'h5A, a} ^ 32'h1234_5678;
    endfunction

    // Synchronous-read data memory; returns a poison word whenever the controller does not own it.
    logic [31:0] memPipe [LAT];
    always @(posedge clk) begin
        memPipe[0] <= dm_sel ? memWord(dm_addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) memPipe[i] <= memPipe[i-1];
    end
    assign dm_rdata = memPipe[LAT-1];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sendCmd(input logic [2:0] op, input logic [AW-1:0] addr);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checkVal("cmd_ready", cmd_ready, 1);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic getRsp(input string tag, input logic [31:0] expData, input logic expErr);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        checkVal({tag, "_valid"}, rsp_valid, 1);
        checkVal({tag, "_data"}, rsp_data, expData);
        checkVal({tag, "_err"}, rsp_err, expErr);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkVal({tag, "_released"}, rsp_valid, 0);
    endtask

    task automatic simpleCmd(input logic [2:0] op);
        sendCmd(op, AW'($urandom));
        checkVal("simple_state", state, S_RESP);
        getRsp("simple", (op == OP_RDCNT) ? mCnt : 32'd0, op == OP_RSVD);
        checkVal("simple_ret", state, mMode);
        checkVal("simple_cnt", cycle_cnt, mCnt);
    endtask

    // endKind: 0 halt_wb at cycle k, 1 STOP at cycle k (optional halt in drain), 2 STOP and halt together
    task automatic runScenario(input int unsigned k, input bit hasMid, input logic [2:0] midOp,
                               input int endKind, input int unsigned drainHalt);
        int unsigned cyc;
        int unsigned nDrain;
        int unsigned expDrain;
        logic [31:0] base = mCnt;
        sendCmd(OP_RUN, '0);
        cyc = 1;
        checkVal("run_state", state, S_RUN);
        checkVal("run_en", pipe_en, 1);
        getRsp("run_ack", 0, 0);
        cyc = 2;
        if (hasMid) begin
            sendCmd(midOp, AW'($urandom));
            cyc = 3;
            getRsp("run_mid", (midOp == OP_RDCNT) ? base + 32'd1 : 32'd0,
                   (midOp != OP_RDCNT) && (midOp != OP_NOP));
            cyc = 4;
            checkVal("run_mid_state", state, S_RUN);
        end
        while (cyc < k) begin
            tick();
            cyc++;
        end
        checkVal("run_en_before_end", pipe_en, 1);
        if (endKind == 0) begin
            halt_wb = 1'b1;
            tick();
            halt_wb = 1'b0;
            mCnt = base + k;
        end else if (endKind == 1) begin
            sendCmd(OP_STOP, '0);
            nDrain = 0;
            while (state == S_DRAIN && nDrain < 20) begin
                checkVal("drain_hold_en", {30'd0, fetch_hold, pipe_en}, 32'd3);
                nDrain++;
                if (drainHalt != 0 && nDrain == drainHalt) halt_wb = 1'b1;
                tick();
                halt_wb = 1'b0;
            end
            expDrain = (drainHalt != 0) ? drainHalt : DRAIN;
            checkVal("drain_len", nDrain, expDrain);
            mCnt = base + k + expDrain;
        end else begin
            checkVal("stop_halt_ready", cmd_ready, 1);
            cmd_op    = OP_STOP;
            cmd_valid = 1'b1;
            halt_wb   = 1'b1;
            tick();
            cmd_valid = 1'b0;
            halt_wb   = 1'b0;
            mCnt = base + k;
        end
        checkVal("halted_state", state, S_HALTED);
        checkVal("halted_en", pipe_en, 0);
        checkVal("halted_hold", fetch_hold, 0);
        if (endKind != 0) getRsp("stop", 0, 0);
        mMode = S_HALTED;
        checkVal("run_cnt", cycle_cnt, mCnt);
    endtask

    task automatic stepScenario(input bit withHalt);
        sendCmd(OP_STEP, '0);
        checkVal("step_state", state, S_STEP);
        checkVal("step_en", pipe_en, 1);
        halt_wb = withHalt;
        tick();
        halt_wb = 1'b0;
        checkVal("step_en_off", pipe_en, 0);
        checkVal("step_resp", state, S_RESP);
        getRsp("step", 0, 0);
        mCnt = mCnt + 32'd1;
        if (withHalt) mMode = S_HALTED;
        checkVal("step_ret", state, mMode);
        checkVal("step_cnt", cycle_cnt, mCnt);
    endtask

    task automatic rdmemScenario(input logic [AW-1:0] addr);
        int n = 0;
        sendCmd(OP_RDMEM, addr);
        while (dm_sel && n < 10) begin
            checkVal("memrd_addr", dm_addr, addr);
            checkVal("memrd_en", pipe_en, 0);
            checkVal("memrd_state", state, S_MEMRD);
            n++;
            tick();
        end
        checkVal("dm_sel_len", n, LAT + 1);
        getRsp("rdmem", memWord(addr), 0);
        checkVal("rdmem_ret", state, mMode);
    endtask

    task automatic rstScenario(input int unsigned delay);
        int n = 0;
        sendCmd(OP_RSTPIPE, '0);
        while (pipe_rst && n < 10) begin
            checkVal("rst_en", pipe_en, 0);
            checkVal("rst_cnt_clear", cycle_cnt, 0);
            n++;
            tick();
        end
        checkVal("pipe_rst_len", n, RSTC);
        for (int unsigned i = 0; i < delay; i++) begin
            checkVal("rst_rsp_held", rsp_valid, 1);
            checkVal("rst_rsp_state", state, S_RESP);
            tick();
        end
        getRsp("rstpipe", 0, 0);
        mCnt  = '0;
        mMode = S_IDLE;
        checkVal("rst_ret", state, S_IDLE);
        checkVal("rst_cnt", cycle_cnt, 0);
    endtask

    initial begin
        logic [2:0] badOps [5];
        logic [2:0] simpleOps [4];
        badOps    = '{OP_RUN, OP_STEP, OP_RDMEM, OP_RSTPIPE, OP_RSVD};
        simpleOps = '{OP_NOP, OP_STOP, OP_RDCNT, OP_RSVD};

        repeat (3) tick();
        checkVal("reset_state", state, S_IDLE);
        checkVal("reset_pipe_rst", pipe_rst, 1);
        checkVal("reset_pipe_en", pipe_en, 0);
        checkVal("reset_rsp_valid", rsp_valid, 0);
        checkVal("reset_cnt", cycle_cnt, 0);
        checkVal("reset_dm_sel", dm_sel, 0);
        inicio = 1'b0;
        tick();
        checkVal("pipe_rst_released", pipe_rst, 0);
        simpleCmd(OP_RDCNT);

        runScenario(10, 1'b0, OP_NOP, 0, 0);
        simpleCmd(OP_RDCNT);
        rstScenario(5);
        runScenario(5, 1'b0, OP_NOP, 1, 0);
        checkVal("stop5_cnt", cycle_cnt, 32'd9);
        rdmemScenario(12'h010);
        rstScenario(0);
        repeat (3) stepScenario(1'b0);
        checkVal("step3_cnt", cycle_cnt, 32'd3);
        runScenario(8, 1'b1, OP_RDMEM, 0, 0);
        runScenario(9, 1'b1, OP_RDCNT, 2, 0);
        runScenario(7, 1'b0, OP_NOP, 1, 2);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: runScenario($urandom_range(5, 25), 1'($urandom_range(0, 1)),
                               ($urandom_range(0, 1) == 0) ? OP_RDCNT : badOps[$urandom_range(0, 4)],
                               int'($urandom_range(0, 2)), $urandom_range(0, DRAIN));
                1: stepScenario(1'($urandom_range(0, 1)));
                2: rdmemScenario(AW'($urandom));
                3: rstScenario($urandom_range(0, 4));
                4: simpleCmd(simpleOps[$urandom_range(0, 3)]);
                default: simpleCmd(OP_RDCNT);
            endcase
        end

        sendCmd(OP_RUN, '0);
        repeat (3) tick();
        #2 inicio = 1'b1;
        #1;
        checkVal("abort_state", state, S_IDLE);
        checkVal("abort_rsp", rsp_valid, 0);
        checkVal("abort_pipe_en", pipe_en, 0);
        checkVal("abort_pipe_rst", pipe_rst, 1);
        checkVal("abort_cnt", cycle_cnt, 0);
        tick();
        inicio = 1'b0;
        tick();
        mCnt  = '0;
        mMode = S_IDLE;
        checkVal("abort_rst_released", pipe_rst, 0);
        simpleCmd(OP_RDCNT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
